// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - parametrised valid/ready pipeline stage with optional 2-entry skid buffer
module pipe_stage_skid #(
    parameter int unsigned      WIDTH     = 105,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             active_q;
    logic             full;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer     = valid_i & ready_o;
    assign out_xfer    = valid_q & ready_i;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign occupancy_o = full ? 2'd2 : (valid_q ? 2'd1 : 2'd0);

    // Out-of-reset flag: keeps ready_o low while reset is held and for the release cycle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic             full_q;
            logic [WIDTH-1:0] skid_q;

            // ready_o is built only from flops, so downstream stalls never reach upstream combinationally
            assign full    = full_q;
            assign ready_o = active_q & ~full_q;

            // EMPTY/HALF/FULL stage: output register plus one skid entry behind it
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    full_q  <= 1'b0;
                    data_q  <= RESET_VAL;
                    skid_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                    full_q  <= 1'b0;
                    skid_q  <= '0;
                end else if (full_q) begin
                    if (out_xfer) begin
                        data_q <= skid_q;
                        full_q <= 1'b0;
                    end
                end else if (valid_q) begin
                    if (in_xfer && out_xfer) begin
                        data_q <= data_i;
                    end else if (in_xfer) begin
                        skid_q <= data_i;
                        full_q <= 1'b1;
                    end else if (out_xfer) begin
                        valid_q <= 1'b0;
                    end
                end else if (in_xfer) begin
                    data_q  <= data_i;
                    valid_q <= 1'b1;
                end
            end
        end else begin : g_single
            // Plain register: accept whenever the held word leaves or nothing is held
            assign full    = 1'b0;
            assign ready_o = active_q & (ready_i | ~valid_q);

            // Single-entry stage register with bubble on flush
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    data_q  <= RESET_VAL;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    data_q  <= data_i;
                    valid_q <= 1'b1;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule
